// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: control-store bus and microword field outputs of the
// micro_sequencer. The master modport is the sequencer side; the slave
// modport is the control store / downstream pipeline side.
interface micro_sequencer_if #(
  parameter int ADDR_W = 8
);
  localparam int WORD_W = ADDR_W + 22;

  logic [ADDR_W-1:0] uaddr;
  logic [WORD_W-1:0] udata;
  logic              flag_z;
  logic              flag_n;
  logic [3:0]        opcode;
  logic              stall;
  logic [3:0]        ALU_out;
  logic [1:0]        SH_out;
  logic [5:0]        C_out;
  logic [6:0]        T_out;
  logic              halted;
  logic              stack_err;

  modport master (
    output uaddr, ALU_out, SH_out, C_out, T_out, halted, stack_err,
    input  udata, flag_z, flag_n, opcode, stall
  );

  modport slave (
    input  uaddr, ALU_out, SH_out, C_out, T_out, halted, stack_err,
    output udata, flag_z, flag_n, opcode, stall
  );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer. Addresses the control store with
// upc, registers the fetched microword fields and selects the next address
// (seq / jmp / jz / jn / dispatch / halt).
// Optional feature macro: MICRO_CALL_EN adds a STACK_D-entry micro-subroutine
// return stack (call/ret) with a sticky stack_err. Without it, call and ret
// behave as seq and stack_err is constant 0.
module micro_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int STACK_D = 4
) (
  input  logic                clock,
  input  logic                reset,
  micro_sequencer_if.master   bus
);
  localparam int WORD_W = ADDR_W + 22;

  localparam logic [2:0] COND_SEQ  = 3'b000;
  localparam logic [2:0] COND_JMP  = 3'b001;
  localparam logic [2:0] COND_JZ   = 3'b010;
  localparam logic [2:0] COND_JN   = 3'b011;
  localparam logic [2:0] COND_CALL = 3'b100;
  localparam logic [2:0] COND_RET  = 3'b101;
  localparam logic [2:0] COND_DISP = 3'b110;
  localparam logic [2:0] COND_HALT = 3'b111;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [3:0]        alu_q, alu_d;
  logic [1:0]        sh_q, sh_d;
  logic [5:0]        c_q, c_d;
  logic [6:0]        t_q, t_d;

  logic [2:0]        cond_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] upc_inc_s;
  logic [ADDR_W+7:0] disp_wide_s;
  logic [ADDR_W-1:0] disp_s;
  logic [ADDR_W-1:0] next_s;
  logic              advance_s;

  assign cond_s      = bus.udata[21:19];
  assign target_s    = bus.udata[WORD_W-1:22];
  assign upc_inc_s   = upc_q + ADDR_W'(1);
  // Opcode lands in bits [7:4]; the wide form makes truncation/extension to
  // any ADDR_W a plain slice.
  assign disp_wide_s = {{ADDR_W{1'b0}}, bus.opcode, 4'b0000};
  assign disp_s      = disp_wide_s[ADDR_W-1:0];
  // Halt ignores stall: only running, unstalled edges advance the sequencer.
  assign advance_s   = (state_q == ST_RUN) && !bus.stall;

`ifdef MICRO_CALL_EN
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_W-1:0] stack_q [STACK_D];
  logic [SP_W-1:0]   sp_q;
  logic              err_q;
  logic              full_s, empty_s;
  logic              push_s, pop_s, err_set_s;
  logic [IDX_W-1:0]  push_idx_s, pop_idx_s;

  assign full_s     = (sp_q == SP_W'(STACK_D));
  assign empty_s    = (sp_q == {SP_W{1'b0}});
  assign push_idx_s = sp_q[IDX_W-1:0];
  // sp is 1..STACK_D whenever a pop happens, so the modular decrement of the
  // low bits addresses the top entry correctly.
  assign pop_idx_s  = sp_q[IDX_W-1:0] - IDX_W'(1);
`endif

  // Next-address selection from the COND field of the current word.
  always_comb begin
    next_s = upc_inc_s;
`ifdef MICRO_CALL_EN
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
`endif
    case (cond_s)
      COND_SEQ: next_s = upc_inc_s;
      COND_JMP: next_s = target_s;
      COND_JZ: begin
        if (bus.flag_z) next_s = target_s;
        else            next_s = upc_inc_s;
      end
      COND_JN: begin
        if (bus.flag_n) next_s = target_s;
        else            next_s = upc_inc_s;
      end
      COND_CALL: begin
`ifdef MICRO_CALL_EN
        // A call on a full stack still jumps; only the push is dropped.
        next_s = target_s;
        if (full_s) err_set_s = 1'b1;
        else        push_s    = 1'b1;
`else
        next_s = upc_inc_s;
`endif
      end
      COND_RET: begin
`ifdef MICRO_CALL_EN
        if (empty_s) begin
          err_set_s = 1'b1;
          next_s    = upc_inc_s;
        end else begin
          pop_s  = 1'b1;
          next_s = stack_q[pop_idx_s];
        end
`else
        next_s = upc_inc_s;
`endif
      end
      COND_DISP: next_s = disp_s;
      COND_HALT: next_s = upc_q;
      default:   next_s = upc_inc_s;
    endcase
  end

  // Sequencer FSM: run/halt transitions, upc and field register next state.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    alu_d   = alu_q;
    sh_d    = sh_q;
    c_d     = c_q;
    t_d     = t_q;
    case (state_q)
      ST_RUN: begin
        if (!bus.stall) begin
          alu_d = bus.udata[18:15];
          sh_d  = bus.udata[14:13];
          c_d   = bus.udata[12:7];
          t_d   = bus.udata[6:0];
          upc_d = next_s;
          if (cond_s == COND_HALT) state_d = ST_HALT;
          else                     state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        alu_d = 4'd0;
        sh_d  = 2'd0;
        c_d   = 6'd0;
        t_d   = 7'd0;
      end
      default: begin
        state_d = ST_HALT;
        alu_d   = 4'd0;
        sh_d    = 2'd0;
        c_d     = 6'd0;
        t_d     = 7'd0;
      end
    endcase
  end

  // State, upc and field registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      upc_q   <= {ADDR_W{1'b0}};
      alu_q   <= 4'd0;
      sh_q    <= 2'd0;
      c_q     <= 6'd0;
      t_q     <= 7'd0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      alu_q   <= alu_d;
      sh_q    <= sh_d;
      c_q     <= c_d;
      t_q     <= t_d;
    end
  end

`ifdef MICRO_CALL_EN
  // Return stack, stack pointer and sticky stack fault.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_q  <= {SP_W{1'b0}};
      err_q <= 1'b0;
      for (int i = 0; i < STACK_D; i++) stack_q[i] <= {ADDR_W{1'b0}};
    end else if (advance_s) begin
      if (push_s) begin
        stack_q[push_idx_s] <= upc_inc_s;
        sp_q                <= sp_q + SP_W'(1);
      end else if (pop_s) begin
        sp_q <= sp_q - SP_W'(1);
      end
      if (err_set_s) err_q <= 1'b1;
    end
  end

  assign bus.stack_err = err_q;
`else
  assign bus.stack_err = 1'b0;
`endif

  assign bus.uaddr   = upc_q;
  assign bus.ALU_out = alu_q;
  assign bus.SH_out  = sh_q;
  assign bus.C_out   = c_q;
  assign bus.T_out   = t_q;
  assign bus.halted  = (state_q == ST_HALT);
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed, table-driven bench for micro_sequencer with a
// behavioural control-store ROM driven combinationally from uaddr.
module tb_micro_sequencer;
  localparam int ADDR_W = 8;
  localparam int WORD_W = ADDR_W + 22;

  localparam logic [2:0] C_SEQ  = 3'b000;
  localparam logic [2:0] C_JMP  = 3'b001;
  localparam logic [2:0] C_JZ   = 3'b010;
  localparam logic [2:0] C_JN   = 3'b011;
  localparam logic [2:0] C_CALL = 3'b100;
  localparam logic [2:0] C_RET  = 3'b101;
  localparam logic [2:0] C_DISP = 3'b110;
  localparam logic [2:0] C_HALT = 3'b111;

  logic clock = 1'b0;
  logic reset = 1'b1;

  micro_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  micro_sequencer #(.ADDR_W(ADDR_W), .STACK_D(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [WORD_W-1:0] rom [0:255];
  assign bus.udata = rom[bus.uaddr];

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       stall;
    logic       fz;
    logic       fn;
    logic [3:0] op;
    logic [7:0] ua;
    logic [3:0] alu;
    logic [1:0] sh;
    logic [5:0] c;
    logic [6:0] t;
    logic       hlt;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [WORD_W-1:0] mk(input logic [7:0] nxt, input logic [2:0] cond,
                                          input logic [3:0] alu, input logic [1:0] sh,
                                          input logic [5:0] c, input logic [6:0] t);
    return {nxt, cond, alu, sh, c, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] ua, input logic [3:0] alu,
                           input logic [1:0] sh, input logic [5:0] c, input logic [6:0] t,
                           input logic hlt, input logic err);
    chk({tag, ".uaddr"},     32'(bus.uaddr),     32'(ua));
    chk({tag, ".ALU_out"},   32'(bus.ALU_out),   32'(alu));
    chk({tag, ".SH_out"},    32'(bus.SH_out),    32'(sh));
    chk({tag, ".C_out"},     32'(bus.C_out),     32'(c));
    chk({tag, ".T_out"},     32'(bus.T_out),     32'(t));
    chk({tag, ".halted"},    32'(bus.halted),    32'(hlt));
    chk({tag, ".stack_err"}, 32'(bus.stack_err), 32'(err));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = {WORD_W{1'b0}};
  endtask

  task automatic set_in(input logic st, input logic fz, input logic fn, input logic [3:0] op);
    bus.stall  = st;
    bus.flag_z = fz;
    bus.flag_n = fn;
    bus.opcode = op;
  endtask

  // Reset across one rising edge, release 1 time unit after it.
  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 4'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 4'h0);

    // ---------------- Phase 1: main program ----------------
    clear_rom();
    rom[8'h00] = mk(8'h00, C_SEQ,  4'h1, 2'd0, 6'h00, 7'h00);
    rom[8'h01] = mk(8'h00, C_SEQ,  4'h2, 2'd0, 6'h00, 7'h00);
    rom[8'h02] = mk(8'h00, C_SEQ,  4'h3, 2'd0, 6'h00, 7'h00);
    rom[8'h03] = mk(8'h00, C_SEQ,  4'h4, 2'd0, 6'h00, 7'h00);
    rom[8'h04] = mk(8'h00, C_SEQ,  4'h5, 2'd2, 6'h00, 7'h00);
    rom[8'h05] = mk(8'h40, C_JZ,   4'h6, 2'd0, 6'h00, 7'h00);
    rom[8'h40] = mk(8'h05, C_JMP,  4'h7, 2'd0, 6'h00, 7'h00);
    rom[8'h06] = mk(8'h50, C_JN,   4'h8, 2'd0, 6'h00, 7'h00);
    rom[8'h50] = mk(8'h00, C_DISP, 4'h9, 2'd0, 6'h00, 7'h00);
    rom[8'hA0] = mk(8'h00, C_SEQ,  4'hA, 2'd0, 6'h00, 7'h55);
    rom[8'hA1] = mk(8'h00, C_SEQ,  4'hB, 2'd0, 6'h12, 7'h00);
    rom[8'hA2] = mk(8'h10, C_JMP,  4'hC, 2'd0, 6'h00, 7'h00);
    rom[8'h10] = mk(8'h00, C_HALT, 4'hD, 2'd0, 6'h3F, 7'h00);

    //          stall fz    fn    op     ua     alu   sh    c      t      hlt
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h01, 4'h1, 2'd0, 6'h00, 7'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 4'h0, 8'h02, 4'h2, 2'd0, 6'h00, 7'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h03, 4'h3, 2'd0, 6'h00, 7'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h04, 4'h4, 2'd0, 6'h00, 7'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h05, 4'h5, 2'd2, 6'h00, 7'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'h0, 8'h40, 4'h6, 2'd0, 6'h00, 7'h00, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h05, 4'h7, 2'd0, 6'h00, 7'h00, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'h0, 8'h06, 4'h6, 2'd0, 6'h00, 7'h00, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'h0, 8'h50, 4'h8, 2'd0, 6'h00, 7'h00, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'hA, 8'hA0, 4'h9, 2'd0, 6'h00, 7'h00, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'hA1, 4'hA, 2'd0, 6'h00, 7'h55, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'h0, 8'hA1, 4'hA, 2'd0, 6'h00, 7'h55, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 4'h0, 8'hA1, 4'hA, 2'd0, 6'h00, 7'h55, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 4'h0, 8'hA1, 4'hA, 2'd0, 6'h00, 7'h55, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'hA2, 4'hB, 2'd0, 6'h12, 7'h00, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h10, 4'hC, 2'd0, 6'h00, 7'h00, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h10, 4'hD, 2'd0, 6'h3F, 7'h00, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h10, 4'h0, 2'd0, 6'h00, 7'h00, 1'b1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h10, 4'h0, 2'd0, 6'h00, 7'h00, 1'b1};

    do_reset();
    check_all("reset", 8'h00, 4'h0, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      set_in(vecs[i].stall, vecs[i].fz, vecs[i].fn, vecs[i].op);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].ua, vecs[i].alu, vecs[i].sh,
                vecs[i].c, vecs[i].t, vecs[i].hlt, 1'b0);
    end
    set_in(1'b0, 1'b0, 1'b0, 4'h0);

    // Asynchronous reset between edges while halted.
    #2;
    reset = 1'b1;
    #1;
    check_all("arst_halt", 8'h00, 4'h0, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
    #1;
    reset = 1'b0;

    // Asynchronous reset mid-stream with non-zero fields.
    step();
    step();
    check_all("pre_arst", 8'h02, 4'h2, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_all("arst_run", 8'h00, 4'h0, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);

    // ---------------- Phase 2: call/ret and wrap ----------------
    clear_rom();
    rom[8'h00] = mk(8'h08, C_JMP,  4'h0, 2'd0, 6'h00, 7'h00);
    rom[8'h08] = mk(8'h20, C_CALL, 4'h4, 2'd0, 6'h00, 7'h00);
    rom[8'h20] = mk(8'h00, C_RET,  4'h6, 2'd0, 6'h00, 7'h00);
    rom[8'h09] = mk(8'h00, C_RET,  4'h5, 2'd0, 6'h00, 7'h00);
    rom[8'h0A] = mk(8'hFF, C_JMP,  4'h7, 2'd0, 6'h00, 7'h00);
    rom[8'hFF] = mk(8'h00, C_SEQ,  4'h8, 2'd0, 6'h00, 7'h00);
    do_reset();
    step();
    check_all("p2_jmp", 8'h08, 4'h0, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
`ifdef MICRO_CALL_EN
    step();
    check_all("p2_call", 8'h20, 4'h4, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
    step();
    check_all("p2_ret", 8'h09, 4'h6, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
    step();
    check_all("p2_ret_empty", 8'h0A, 4'h5, 2'd0, 6'h00, 7'h00, 1'b0, 1'b1);
    step();
    check_all("p2_to_ff", 8'hFF, 4'h7, 2'd0, 6'h00, 7'h00, 1'b0, 1'b1);
    step();
    check_all("p2_wrap", 8'h00, 4'h8, 2'd0, 6'h00, 7'h00, 1'b0, 1'b1);

    // Five nested calls on a four-deep stack.
    clear_rom();
    rom[8'h00] = mk(8'h30, C_JMP,  4'h0, 2'd0, 6'h00, 7'h00);
    rom[8'h30] = mk(8'h31, C_CALL, 4'h1, 2'd0, 6'h00, 7'h00);
    rom[8'h31] = mk(8'h32, C_CALL, 4'h2, 2'd0, 6'h00, 7'h00);
    rom[8'h32] = mk(8'h33, C_CALL, 4'h3, 2'd0, 6'h00, 7'h00);
    rom[8'h33] = mk(8'h34, C_CALL, 4'h4, 2'd0, 6'h00, 7'h00);
    rom[8'h34] = mk(8'h35, C_CALL, 4'h5, 2'd0, 6'h00, 7'h00);
    rom[8'h36] = mk(8'h00, C_RET,  4'h6, 2'd0, 6'h00, 7'h00);
    do_reset();
    check_all("nest_reset", 8'h00, 4'h0, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
    step();
    check_all("nest0", 8'h30, 4'h0, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_all($sformatf("nest%0d", i), 8'(8'h30 + i), 4'(i), 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
    end
    step();
    check_all("nest5_full", 8'h35, 4'h5, 2'd0, 6'h00, 7'h00, 1'b0, 1'b1);
    step();
    check_all("nest_sticky", 8'h36, 4'h0, 2'd0, 6'h00, 7'h00, 1'b0, 1'b1);
    step();
    check_all("nest_ret_top", 8'h34, 4'h6, 2'd0, 6'h00, 7'h00, 1'b0, 1'b1);
    do_reset();
    check_all("err_cleared", 8'h00, 4'h0, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
`else
    step();
    check_all("p2_call_seq", 8'h09, 4'h4, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
    step();
    check_all("p2_ret_seq", 8'h0A, 4'h5, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
    step();
    check_all("p2_to_ff", 8'hFF, 4'h7, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
    step();
    check_all("p2_wrap", 8'h00, 4'h8, 2'd0, 6'h00, 7'h00, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer feeding the microinstruction pipeline. It addresses the control store, registers the fetched microword, and presents the ALU/SH/C/T field bundle that the downstream pipeline stage latches. Next-address selection supports sequential flow, unconditional and flag-conditional jumps, opcode dispatch, halt, and an optional micro-subroutine stack.

## Interface
Parameters:
- ADDR_W, 8: micro-address width. Derived localparam WORD_W = ADDR_W+22.
- STACK_D, 4: micro-subroutine stack depth. Used only with MICRO_CALL_EN.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- uaddr  out  ADDR_W  control-store address; equals the internal upc.
- udata  in  WORD_W  control-store word, combinationally valid for uaddr in the same cycle. Layout: T[6:0], C[12:7], SH[14:13], ALU[18:15], COND[21:19], NEXT[WORD_W-1:22].
- flag_z  in  1  datapath zero flag, sampled at the fetch edge.
- flag_n  in  1  datapath negative flag, sampled at the fetch edge.
- opcode  in  4  macro-instruction opcode used by dispatch.
- stall  in  1  freeze request.
- ALU_out  out  4  registered ALU field.
- SH_out  out  2  registered shifter field.
- C_out  out  6  registered register-write field.
- T_out  out  7  registered transfer/bus field.
- halted  out  1  sequencer has stopped.
- stack_err  out  1  sticky stack fault. Tied to 0 without MICRO_CALL_EN.

## Operation
- Per clock edge with stall=0 and halted=0: field registers load from udata(upc); upc loads next_addr.
- COND encoding and next_addr:
  - 000 seq: upc+1.
  - 001 jmp: NEXT.
  - 010 jz: NEXT if flag_z, else upc+1.
  - 011 jn: NEXT if flag_n, else upc+1.
  - 100 call: see Configuration.
  - 101 ret: see Configuration.
  - 110 dispatch: {opcode, 4'b0000} truncated or zero-extended to ADDR_W.
  - 111 halt: fields of this word are output for one cycle. halted=1 from the same edge and upc holds.
- upc+1 wraps from 2^ADDR_W-1 to 0.
- While halted:
  - At the next edge the outputs become all-zero (NOP) and stay so.
  - stall is ignored.
  - Only reset exits this state.
- stall=1 at an edge: upc, fields, stack and sp all hold. Flags are not sampled.

## Timing
- Reset values: upc=0, uaddr=0, ALU_out=SH_out=C_out=T_out=0, halted=0, stack_err=0, sp=0.
- Latency: the word at address A appears on the field outputs one edge after uaddr=A.
- The first edge after reset deasserts outputs word 0.
- Branch penalty is 0: a taken branch fetches its target on the following edge.
- Flags, opcode and stall must be stable at the rising edge. They are used combinationally only for next_addr.
- Reset asserted mid-stream clears everything asynchronously, including a partially used stack. There is no pending state.

## Configuration
- MICRO_CALL_EN defined: an STACK_D-entry return stack with pointer sp.
  - call: pushes upc+1 and jumps to NEXT.
  - call with a full stack: sets stack_err (sticky until reset), drops the push, and still jumps to NEXT.
  - ret: pops and jumps to the popped address.
  - ret with an empty stack: sets stack_err and continues at upc+1.
- MICRO_CALL_EN undefined:
  - No stack logic is built.
  - COND 100 and 101 behave as seq.
  - stack_err is constant 0.

## Test plan
- Reset then release, sequential ROM words 0..3 with ALU=1..4 → ALU_out reads 0,1,2,3,4 on successive edges; uaddr reads 0,1,2,3,4.
- Word 5 is jz NEXT=0x40. flag_z=1 → uaddr=0x40 next cycle. Repeat with flag_z=0 → uaddr=6.
- Dispatch with opcode=0xA → uaddr=0xA0 next cycle. Stall held for 3 cycles mid-stream → uaddr and all fields constant, then resume at the same address.
- Halt word at 0x10 with C=0x3F → C_out=0x3F for one cycle, then 0, halted=1, and uaddr frozen at 0x10. Assert reset asynchronously between edges → outputs 0 immediately.
- MICRO_CALL_EN: call to 0x20 from 0x08, ret at 0x20 → uaddr sequence 0x08, 0x20, 0x09. Five nested calls → stack_err=1 on the fifth. ret on an empty stack → stack_err=1 and uaddr=upc+1.
- Without MICRO_CALL_EN: a call word at 0x08 → uaddr=0x09 and stack_err=0. Sequential run from 0xFF → wraps to 0x00.
